pipe_stage_latch: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (IF/ID, ID/EX,
//  EX/MEM, MEM/WB). Generic successor to the fixed per-stage latches: carries a valid bit,

---
 rtl/pipe_stage_latch_if.sv | 38 +++
 rtl/pipe_stage_latch.sv | 99 +++++++++
 tb/tb_pipe_stage_latch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_latch_if.sv
// Stage-to-stage bundle: upstream payload and strobes in, registered payload and perf counters out.
interface pipe_stage_latch_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int REQ_W  = 2,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 32
);
    logic              en_i;
    logic              stall_i;
    logic              flush_i;
    logic              dhit_i;
    logic              valid_i;
    logic              halt_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [REQ_W-1:0]  req_i;
    logic [RD_W-1:0]   rd_i;
    logic [DATA_W-1:0] data_i;

    logic              valid_o;
    logic              halt_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [REQ_W-1:0]  req_o;
    logic [RD_W-1:0]   rd_o;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output en_i, stall_i, flush_i, dhit_i, valid_i, halt_i, ctrl_i, req_i, rd_i, data_i,
        input  valid_o, halt_o, ctrl_o, req_o, rd_o, data_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  en_i, stall_i, flush_i, dhit_i, valid_i, halt_i, ctrl_i, req_i, rd_i, data_i,
        output valid_o, halt_o, ctrl_o, req_o, rd_o, data_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with stall hold, flush-to-bubble, dhit request clear, sticky halt.
// Latency 1 cycle on load; stall holds contents, halt freezes everything until reset.
// PIPE_PERF_CNT_EN adds saturating stall/flush cycle counters; otherwise counters read 0.
module pipe_stage_latch #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int REQ_W  = 2,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    pipe_stage_latch_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t state, state_nxt;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [REQ_W-1:0]  req_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] data_q;

    logic do_flush, do_load;

    assign do_flush = bus.flush_i;
    assign do_load  = !bus.flush_i && bus.en_i && !bus.stall_i;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_nxt;
    end

    // Only a load carrying a valid halting instruction freezes the stage.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (do_load && bus.valid_i && bus.halt_i) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            req_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (state == RUN) begin
            if (do_flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                req_q   <= '0;
                rd_q    <= '0;
                data_q  <= '0;
            end else if (do_load) begin
                valid_q <= bus.valid_i;
                ctrl_q  <= bus.ctrl_i;
                req_q   <= bus.req_i;
                rd_q    <= bus.rd_i;
                data_q  <= bus.data_i;
            end else if (bus.dhit_i) begin
                req_q   <= '0;
            end
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.halt_o  = (state == HALTED);
    assign bus.ctrl_o  = ctrl_q;
    assign bus.req_o   = req_q;
    assign bus.rd_o    = rd_q;
    assign bus.data_o  = data_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            if (bus.en_i && bus.stall_i && !bus.flush_i && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush_i && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: directed scenarios then random traffic against a reference model.
module tb_pipe_stage_latch;
    localparam int DATA_W  = 128;
    localparam int CTRL_W  = 8;
    localparam int REQ_W   = 2;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipe_stage_latch_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REQ_W(REQ_W), .RD_W(RD_W), .CNT_W(CNT_W)) bus();

    pipe_stage_latch #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REQ_W(REQ_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the architectural contents of the stage plus plain integer counters.
    typedef struct {
        bit                valid;
        bit                halt;
        logic [CTRL_W-1:0] ctrl;
        logic [REQ_W-1:0]  req;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        int                stalls;
        int                flushes;
    } stage_t;

    stage_t m;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 0, halt: 0, ctrl: '0, req: '0, rd: '0, data: '0, stalls: 0, flushes: 0};
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_step();
        if (m.halt) return;
        if (bus.flush_i) begin
            m.flushes = sat_inc(m.flushes);
            m.valid = 0; m.halt = 0; m.ctrl = '0; m.req = '0; m.rd = '0; m.data = '0;
        end else begin
            if (bus.en_i && bus.stall_i) m.stalls = sat_inc(m.stalls);
            if (bus.en_i && !bus.stall_i) begin
                m.valid = bus.valid_i;
                m.halt  = bus.valid_i && bus.halt_i;
                m.ctrl  = bus.ctrl_i;
                m.req   = bus.req_i;
                m.rd    = bus.rd_i;
                m.data  = bus.data_i;
            end else if (bus.dhit_i) begin
                m.req = '0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".valid"}, bus.valid_o, m.valid);
        check_eq({tag, ".halt"},  bus.halt_o,  m.halt);
        check_eq({tag, ".ctrl"},  bus.ctrl_o,  m.ctrl);
        check_eq({tag, ".req"},   bus.req_o,   m.req);
        check_eq({tag, ".rd"},    bus.rd_o,    m.rd);
        check_eq({tag, ".data"},  bus.data_o,  m.data);
        check_eq({tag, ".scnt"},  bus.stall_cnt_o, PERF ? m.stalls  : 0);
        check_eq({tag, ".fcnt"},  bus.flush_cnt_o, PERF ? m.flushes : 0);
    endtask

    task automatic drive(input logic en, stall, flush, dhit, valid, halt,
                         input logic [CTRL_W-1:0] ctrl, input logic [REQ_W-1:0] req,
                         input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] data);
        bus.en_i = en;       bus.stall_i = stall; bus.flush_i = flush; bus.dhit_i = dhit;
        bus.valid_i = valid; bus.halt_i = halt;   bus.ctrl_i = ctrl;   bus.req_i = req;
        bus.rd_i = rd;       bus.data_i = data;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle with every input high; outputs must clear before the next edge.
    task automatic reset_mid(input string tag);
        drive(1, 1, 1, 1, 1, 1, '1, '1, '1, '1);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge CLK);
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    logic [DATA_W-1:0] d3, d5;

    initial begin
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        model_reset();
        #1;
        check_all("por");
        @(negedge CLK);
        nRST = 1'b1;

        // A halting all-ones load first, so the reset check also proves halt is cleared.
        drive(1, 0, 0, 0, 1, 1, '1, '1, '1, '1);
        tick("pre_halt");
        check_eq("pre_halt_set", bus.halt_o, 1'b1);
        reset_mid("t1_reset");

        drive(1, 0, 0, 0, 1, 0, 8'h3c, 2'b00, 5'd9, {4{32'hA5A5A5A5}});
        tick("t2");
        check_eq("t2_rd", bus.rd_o, 5'd9);
        check_eq("t2_data", bus.data_o, {4{32'hA5A5A5A5}});
        check_eq("t2_valid", bus.valid_o, 1'b1);

        d3 = rnd_data();
        drive(1, 0, 0, 0, 1, 0, 8'h11, 2'b01, 5'd7, d3);
        tick("t3_load");
        check_eq("t3_req_loaded", bus.req_o, 2'b01);
        drive(1, 1, 0, 0, 1, 0, 8'hff, 2'b11, 5'd30, rnd_data());
        tick("t3_s1");
        check_eq("t3_req_s1", bus.req_o, 2'b01);
        drive(1, 1, 0, 1, 1, 0, 8'hff, 2'b11, 5'd30, rnd_data());
        tick("t3_s2");
        check_eq("t3_req_dhit", bus.req_o, 2'b00);
        drive(1, 1, 0, 0, 1, 0, 8'hff, 2'b11, 5'd30, rnd_data());
        tick("t3_s3");
        check_eq("t3_rd_held", bus.rd_o, 5'd7);
        check_eq("t3_data_held", bus.data_o, d3);
        check_eq("t3_stall_cnt", bus.stall_cnt_o, PERF ? 3 : 0);

        drive(0, 1, 1, 0, 1, 0, 8'h77, 2'b11, 5'd21, rnd_data());
        tick("t4");
        check_eq("t4_data", bus.data_o, '0);
        check_eq("t4_rd", bus.rd_o, '0);
        check_eq("t4_flush_cnt", bus.flush_cnt_o, PERF ? 1 : 0);

        d5 = rnd_data();
        drive(1, 0, 0, 0, 1, 1, 8'h5a, 2'b10, 5'd3, d5);
        tick("t5_load");
        check_eq("t5_halt", bus.halt_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'($urandom_range(1)), 1, 1, 1, 0, 8'($urandom), 2'($urandom), 5'($urandom), rnd_data());
            tick("t5_frozen");
        end
        check_eq("t5_data_frozen", bus.data_o, d5);
        check_eq("t5_req_frozen", bus.req_o, 2'b10);
        reset_mid("t5_reset");
        check_eq("t5_halt_cleared", bus.halt_o, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 1, 0, 8'($urandom), 2'($urandom), 5'($urandom), rnd_data());
            tick("t6");
        end
        check_eq("t6_sat", bus.stall_cnt_o, PERF ? CNT_MAX : 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1, 0, 8'($urandom), 2'($urandom), 5'($urandom), rnd_data());
            tick("t6_hold");
        end
        check_eq("t6_sat_hold", bus.stall_cnt_o, PERF ? CNT_MAX : 0);

        for (int i = 0; i < 400; i++) begin
            if (m.halt && $urandom_range(3) == 0) begin
                reset_mid("rnd_reset");
            end else begin
                drive($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
                      $urandom_range(1) == 1, $urandom_range(3) != 0, $urandom_range(15) == 0,
                      8'($urandom), 2'($urandom), 5'($urandom), rnd_data());
                tick("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
